// File: rtl/conv_output_writer.sv
// Output-side SRAM writer: packs convolution result bits MSB-first into row words,
// writes each closed row at an auto-incrementing address and ends a frame with a marker word.
module conv_output_writer #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 12,
  parameter logic [DATA_W-1:0] END_MARKER = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              row_close,
  input  logic              frame_done,
  output logic              in_ready,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [DATA_W-1:0] sram_write_data,
  output logic [ADDR_W-1:0] rows_written,
  output logic              col_overflow,
  output logic              addr_wrap
);

  localparam int               COL_W    = $clog2(DATA_W + 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_FLUSH = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_next;
  logic [DATA_W-1:0] row_buf;
  logic [DATA_W-1:0] row_next;
  logic              accept;
  logic              ovf_hit;
  logic              take_row;

  // Row buffer as it looks after this cycle's bit, so a close in the same cycle includes it
  always_comb begin
    accept   = (state == S_IDLE) || (state == S_ACC);
    row_next = row_buf;
    col_next = col;
    ovf_hit  = 1'b0;
    if (accept && bit_valid) begin
      if (col == COL_FULL) begin
        ovf_hit = 1'b1;
      end else begin
        for (int i = 0; i < DATA_W; i++) begin
          if (i == DATA_W - 1 - int'(col)) begin
            row_next[i] = bit_in;
          end else begin
            row_next[i] = row_buf[i];
          end
        end
        col_next = col + 1'b1;
      end
    end else begin
      ovf_hit = 1'b0;
    end
    // frame_done with a partial row pending flushes that row before the marker
    take_row = accept && (row_close || (frame_done && (col_next != {COL_W{1'b0}})));
  end

  // Control FSM with registered SRAM write port and status outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state              <= S_IDLE;
      wptr               <= {ADDR_W{1'b0}};
      col                <= {COL_W{1'b0}};
      row_buf            <= {DATA_W{1'b0}};
      in_ready           <= 1'b1;
      sram_write_enable  <= 1'b0;
      sram_write_address <= {ADDR_W{1'b0}};
      sram_write_data    <= {DATA_W{1'b0}};
      rows_written       <= {ADDR_W{1'b0}};
      col_overflow       <= 1'b0;
      addr_wrap          <= 1'b0;
    end else begin
      sram_write_enable <= 1'b0;
      case (state)
        S_IDLE, S_ACC: begin
          if (ovf_hit) begin
            col_overflow <= 1'b1;
          end
          if (take_row) begin
            sram_write_enable  <= 1'b1;
            sram_write_address <= wptr;
            sram_write_data    <= row_next;
            wptr               <= wptr + 1'b1;
            rows_written       <= rows_written + 1'b1;
            row_buf            <= {DATA_W{1'b0}};
            col                <= {COL_W{1'b0}};
            if (wptr == {ADDR_W{1'b1}}) begin
              addr_wrap <= 1'b1;
            end
            if (frame_done) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else if (frame_done) begin
            sram_write_enable  <= 1'b1;
            sram_write_address <= wptr;
            sram_write_data    <= END_MARKER;
            state              <= S_END;
            in_ready           <= 1'b0;
          end else begin
            row_buf <= row_next;
            col     <= col_next;
            state   <= (col_next != {COL_W{1'b0}}) ? S_ACC : S_IDLE;
          end
        end
        S_FLUSH: begin
          sram_write_enable  <= 1'b1;
          sram_write_address <= wptr;
          sram_write_data    <= END_MARKER;
          state              <= S_END;
        end
        S_END: begin
          wptr         <= {ADDR_W{1'b0}};
          rows_written <= {ADDR_W{1'b0}};
          in_ready     <= 1'b1;
          state        <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_output_writer.sv
// Self-checking bench for conv_output_writer: directed scenarios plus random traffic
// compared against a queue-based behavioural model of the writer.
module tb_conv_output_writer;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        bit_valid = 1'b0, bit_in = 1'b0, row_close = 1'b0, frame_done = 1'b0;
  logic        in_ready, sram_write_enable, col_overflow, addr_wrap;
  logic [11:0] sram_write_address, rows_written;
  logic [15:0] sram_write_data;

  logic        s_bv = 1'b0, s_bi = 1'b0, s_rc = 1'b0, s_fd = 1'b0;
  logic        s_ready, s_we, s_ovf, s_wrap;
  logic [1:0]  s_addr, s_rows;
  logic [15:0] s_data;

  int checks = 0;
  int fails  = 0;

  conv_output_writer dut (
    .clk(clk), .reset_b(reset_b), .bit_valid(bit_valid), .bit_in(bit_in),
    .row_close(row_close), .frame_done(frame_done), .in_ready(in_ready),
    .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
    .sram_write_data(sram_write_data), .rows_written(rows_written),
    .col_overflow(col_overflow), .addr_wrap(addr_wrap)
  );

  conv_output_writer #(.DATA_W(16), .ADDR_W(2), .END_MARKER(16'hFFFF)) dut_small (
    .clk(clk), .reset_b(reset_b), .bit_valid(s_bv), .bit_in(s_bi),
    .row_close(s_rc), .frame_done(s_fd), .in_ready(s_ready),
    .sram_write_enable(s_we), .sram_write_address(s_addr),
    .sram_write_data(s_data), .rows_written(s_rows),
    .col_overflow(s_ovf), .addr_wrap(s_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // Behavioural model: row as a queue of bits, pointer/counters as plain integers
  int          m_bits[$];
  int          m_wptr, m_rows, m_stall;
  bit          m_pend, m_ovf, m_wrap;
  logic        e_we, e_ready;
  logic [11:0] e_addr, e_rows;
  logic [15:0] e_data;

  function automatic logic [15:0] pack_row();
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < m_bits.size(); i++) w = w | (16'(m_bits[i]) << (15 - i));
    return w;
  endfunction

  function automatic void model_reset();
    m_bits.delete();
    m_wptr = 0; m_rows = 0; m_stall = 0; m_pend = 1'b0; m_ovf = 1'b0; m_wrap = 1'b0;
    e_we = 1'b0; e_ready = 1'b1; e_addr = 12'h000; e_data = 16'h0000; e_rows = 12'h000;
  endfunction

  function automatic void model_step(input bit bv, input bit bi, input bit rc, input bit fd);
    e_we = 1'b0;
    if (m_stall == 0) begin
      if (bv) begin
        if (m_bits.size() < 16) m_bits.push_back(int'(bi));
        else m_ovf = 1'b1;
      end
      if (rc || (fd && m_bits.size() > 0)) begin
        e_we = 1'b1; e_addr = 12'(m_wptr); e_data = pack_row();
        m_wptr = (m_wptr + 1) % 4096;
        if (m_wptr == 0) m_wrap = 1'b1;
        m_rows = (m_rows + 1) % 4096;
        m_bits.delete();
        if (fd) begin m_pend = 1'b1; m_stall = 2; end
      end else if (fd) begin
        e_we = 1'b1; e_addr = 12'(m_wptr); e_data = 16'hFFFF; m_stall = 1;
      end
    end else begin
      if (m_pend) begin
        e_we = 1'b1; e_addr = 12'(m_wptr); e_data = 16'hFFFF; m_pend = 1'b0;
      end else begin
        m_wptr = 0; m_rows = 0;
      end
      m_stall--;
    end
    e_ready = (m_stall == 0);
    e_rows  = 12'(m_rows);
  endfunction

  task automatic cyc(input bit bv, input bit bi, input bit rc, input bit fd);
    bit_valid = bv; bit_in = bi; row_close = rc; frame_done = fd;
    model_step(bv, bi, rc, fd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit_valid = 1'b0; bit_in = 1'b0; row_close = 1'b0; frame_done = 1'b0;
    s_bv = 1'b0; s_bi = 1'b0; s_rc = 1'b0; s_fd = 1'b0;
    reset_b = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset_b = 1'b0;
    #1;
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data, rows_written, col_overflow, addr_wrap} !== 43'd0) begin
      fails++; $display("FAIL reset_outputs: got we=%b addr=%h data=%h rows=%h ovf=%b wrap=%b, want all 0",
        sram_write_enable, sram_write_address, sram_write_data, rows_written, col_overflow, addr_wrap);
    end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    reset_b = 1'b1;
  endtask

  task automatic test_single_row();
    bit pat[14] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    int early_we = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, pat[i], 1'b0, 1'b0);
      if (sram_write_enable !== 1'b0) early_we++;
    end
    checks++;
    if (early_we != 0) begin fails++; $display("FAIL single_no_early_write: got %0d writes want 0", early_we); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data} !== {1'b1, 12'h000, 16'hB004}) begin
      fails++; $display("FAIL single_write: got we=%b addr=%h data=%h want we=1 addr=000 data=b004",
        sram_write_enable, sram_write_address, sram_write_data);
    end
    checks++;
    if (rows_written !== 12'd1) begin fails++; $display("FAIL single_rows: got %0d want 1", rows_written); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data} !== {1'b0, 12'h000, 16'hB004}) begin
      fails++; $display("FAIL single_hold: got we=%b addr=%h data=%h want we=0 addr=000 data=b004",
        sram_write_enable, sram_write_address, sram_write_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({sram_write_enable, sram_write_address, sram_write_data} !== {1'b1, 12'(k), 16'h8000}) begin
        fails++; $display("FAIL b2b_write%0d: got we=%b addr=%h data=%h want we=1 addr=%0d data=8000",
          k, sram_write_enable, sram_write_address, sram_write_data, k);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sram_write_enable !== 1'b0) begin fails++; $display("FAIL b2b_deassert: got we=%b want 0", sram_write_enable); end
  endtask

  task automatic test_frame_partial();
    int low_cycles = 0;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    if (in_ready === 1'b0) low_cycles++;
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data} !== {1'b1, 12'h000, 16'hF800}) begin
      fails++; $display("FAIL frame_flush: got we=%b addr=%h data=%h want we=1 addr=000 data=f800",
        sram_write_enable, sram_write_address, sram_write_data);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    if (in_ready === 1'b0) low_cycles++;
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data} !== {1'b1, 12'h001, 16'hFFFF}) begin
      fails++; $display("FAIL frame_marker: got we=%b addr=%h data=%h want we=1 addr=001 data=ffff",
        sram_write_enable, sram_write_address, sram_write_data);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    if (in_ready === 1'b0) low_cycles++;
    checks++;
    if (low_cycles != 2) begin fails++; $display("FAIL frame_ready_low: got %0d cycles want 2", low_cycles); end
    checks++;
    if ({sram_write_enable, rows_written} !== {1'b0, 12'h000}) begin
      fails++; $display("FAIL frame_rewind: got we=%b rows=%0d want we=0 rows=0", sram_write_enable, rows_written);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data} !== {1'b1, 12'h000, 16'h0000}) begin
      fails++; $display("FAIL frame_next_addr: got we=%b addr=%h data=%h want we=1 addr=000 data=0000",
        sram_write_enable, sram_write_address, sram_write_data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (col_overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0 after 16 bits", col_overflow); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data, col_overflow} !== {1'b1, 12'h000, 16'hFFFF, 1'b1}) begin
      fails++; $display("FAIL ovf_write: got we=%b addr=%h data=%h ovf=%b want we=1 addr=000 data=ffff ovf=1",
        sram_write_enable, sram_write_address, sram_write_data, col_overflow);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sram_write_address, sram_write_data, col_overflow} !== {12'h001, 16'h0000, 1'b1}) begin
      fails++; $display("FAIL ovf_sticky: got addr=%h data=%h ovf=%b want addr=001 data=0000 ovf=1",
        sram_write_address, sram_write_data, col_overflow);
    end
  endtask

  task automatic test_wrap();
    bit b;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      b = 1'($urandom_range(0, 1));
      s_bv = 1'b1; s_bi = b; s_rc = 1'b1; s_fd = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({s_we, s_addr, s_data, s_wrap} !== {1'b1, 2'(r % 4), {b, 15'h0000}, (r >= 3)}) begin
        fails++; $display("FAIL wrap_row%0d: got we=%b addr=%0d data=%h wrap=%b want we=1 addr=%0d data=%h wrap=%b",
          r, s_we, s_addr, s_data, s_wrap, r % 4, {b, 15'h0000}, (r >= 3));
      end
    end
    s_bv = 1'b0; s_bi = 1'b0; s_rc = 1'b0;
  endtask

  task automatic test_reset_mid_row();
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    bit_valid = 1'b0; bit_in = 1'b0;
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data, rows_written, col_overflow, addr_wrap, in_ready} !== {43'd0, 1'b1}) begin
      fails++; $display("FAIL midreset_outputs: got we=%b addr=%h data=%h rows=%h ready=%b want zeros and ready=1",
        sram_write_enable, sram_write_address, sram_write_data, rows_written, in_ready);
    end
    reset_b = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sram_write_enable !== 1'b0) begin fails++; $display("FAIL midreset_no_write: got we=%b want 0", sram_write_enable); end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({sram_write_enable, sram_write_address, sram_write_data} !== {1'b1, 12'h000, 16'h4000}) begin
      fails++; $display("FAIL midreset_next_row: got we=%b addr=%h data=%h want we=1 addr=000 data=4000",
        sram_write_enable, sram_write_address, sram_write_data);
    end
  endtask

  task automatic test_random();
    bit bv, bi, rc, fd;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bv = ($urandom_range(0, 99) < 70);
      bi = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 99) < 8);
      fd = ($urandom_range(0, 99) < 4);
      cyc(bv, bi, rc, fd);
      checks++;
      if (sram_write_enable !== e_we) begin
        fails++; $display("FAIL rand_we@%0d: got %b want %b", n, sram_write_enable, e_we);
      end
      if (e_we) begin
        checks++;
        if ({sram_write_address, sram_write_data} !== {e_addr, e_data}) begin
          fails++; $display("FAIL rand_word@%0d: got addr=%h data=%h want addr=%h data=%h",
            n, sram_write_address, sram_write_data, e_addr, e_data);
        end
      end
      checks++;
      if ({in_ready, rows_written, col_overflow, addr_wrap} !== {e_ready, e_rows, m_ovf, m_wrap}) begin
        fails++; $display("FAIL rand_status@%0d: got ready=%b rows=%0d ovf=%b wrap=%b want ready=%b rows=%0d ovf=%b wrap=%b",
          n, in_ready, rows_written, col_overflow, addr_wrap, e_ready, e_rows, m_ovf, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_frame_partial();
    test_overflow();
    test_wrap();
    test_reset_mid_row();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
